// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
//   Shared types and helpers for the ALU multdiv unit.
//
//   div_state_e : divider control states
//     IDLE - waiting for a start pulse
//     RUN  - retiring one quotient bit per clock
//     FIX  - applying result signs, publishing outputs, pulsing ready
//     DZ   - single-cycle divide-by-zero completion
//   div_cnt_w() : width of the iteration counter for a given operand width
//                 (the counter must hold WIDTH-1)
// -----------------------------------------------------------------------------
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DZ   = 2'd3
    } div_state_e;

    // CNT_W = $clog2(WIDTH). A function is used because the operand width is
    // a parameter of the instantiating module, not of the package.
    function automatic int div_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/div_sign_fix.sv
// -----------------------------------------------------------------------------
// div_sign_fix
//   Combinational conditional two's-complement negate. Used for taking operand
//   magnitudes and for re-applying signs to quotient and remainder.
//
//   Parameters
//     WIDTH  - data width in bits
//   Ports
//     i_neg  in   1      1: output = -i_val; 0: output = i_val
//     i_val  in   WIDTH  input value
//     o_val  out  WIDTH  conditionally negated value
//
//   Negating the most-negative value wraps to itself; read as unsigned that is
//   exactly 2^(WIDTH-1), which is the magnitude the divider needs.
// -----------------------------------------------------------------------------
module div_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_val
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] w_negated;

    assign w_negated = (~i_val) + ONE;
    assign o_val     = i_neg ? w_negated : i_val;

endmodule

// File: rtl/iterative_divider.sv
// -----------------------------------------------------------------------------
// iterative_divider
//   Sequential restoring (shift-subtract) divider, one quotient bit per clock,
//   with optional two's-complement operands. Sits beside the multiplier in the
//   ALU multdiv unit; pipeline control stalls on ctrl_DIV until data_resultRDY.
//
//   Parameters
//     WIDTH   - operand/result width in bits (>= 2)
//     SIGNED  - 1: two's-complement operands, 0: unsigned
//
//   Ports
//     clock           in   1      rising-edge clock
//     reset           in   1      asynchronous, active-high; clears all state
//     ctrl_DIV        in   1      start pulse; operands sampled on this edge
//     data_operandA   in   WIDTH  dividend
//     data_operandB   in   WIDTH  divisor
//     data_result     out  WIDTH  quotient, truncated toward zero
//     data_remainder  out  WIDTH  remainder, sign follows the dividend
//     data_exception  out  1      divide-by-zero or signed overflow
//     data_resultRDY  out  1      one-cycle pulse; outputs valid while high
//     o_dbg_state     out  2      current controller state (div_state_e)
//
//   Handshake: ctrl_DIV is a fire-and-forget start with no ready back-pressure;
//   a start in any state discards the operation in flight and begins the new
//   one on the same edge. data_resultRDY is a single-cycle valid pulse with no
//   ready; the result registers hold their value until the next pulse.
//
//   Timing (start edge = t0):
//     divisor != 0 : RUN on t1..tWIDTH, FIX on tWIDTH+1, RDY high after it
//     divisor == 0 : DZ completes on t1, RDY high after it
// -----------------------------------------------------------------------------
module iterative_divider
    import multdiv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SIGNED = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic [1:0]       o_dbg_state
);

    localparam int             CNT_W   = div_cnt_w(WIDTH);
    localparam logic           SGN     = (SIGNED != 0);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    div_state_e       r_state;
    logic [WIDTH-1:0] r_rem;     // partial remainder R
    logic [WIDTH-1:0] r_quo;     // dividend magnitude shifting out / Q in
    logic [WIDTH-1:0] r_bmag;    // divisor magnitude |B|
    logic [CNT_W-1:0] r_cnt;     // iterations remaining after this one
    logic             r_sign_q;  // negate quotient at FIX
    logic             r_sign_r;  // negate remainder at FIX
    logic             r_ovf;     // most-negative / -1 detected at start

    // ------------------------------------------------------------------
    // Operand conditioning (only meaningful in signed mode)
    // ------------------------------------------------------------------
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;
    logic             w_ovf;

    assign w_a_neg  = SGN & data_operandA[WIDTH-1];
    assign w_b_neg  = SGN & data_operandB[WIDTH-1];
    assign w_b_zero = (data_operandB == '0);
    assign w_ovf    = SGN & (data_operandA == MOST_NEG) & (data_operandB == '1);

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
        .i_neg (w_a_neg),
        .i_val (data_operandA),
        .o_val (w_a_mag)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
        .i_neg (w_b_neg),
        .i_val (data_operandB),
        .o_val (w_b_mag)
    );

    // ------------------------------------------------------------------
    // Iteration datapath
    // ------------------------------------------------------------------
    // {R,Q} << 1 brings the next dividend bit into R. The shifted remainder
    // needs WIDTH+1 bits because R < |B| <= 2^WIDTH-1 in unsigned mode.
    // The trial difference is taken at the same WIDTH+1 bits: since
    // shifted < 2*|B|, bit WIDTH of the difference is set exactly when the
    // subtraction borrowed, so it serves as the sign of the trial.
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_trial_neg;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    assign w_shift     = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = w_shift - {1'b0, r_bmag};
    assign w_trial_neg = w_trial[WIDTH];
    // When the trial is negative the shifted remainder is below |B|, so its
    // top bit is zero and the low WIDTH bits hold it exactly.
    assign w_rem_next  = w_trial_neg ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_next  = {r_quo[WIDTH-2:0], ~w_trial_neg};

    // ------------------------------------------------------------------
    // Sign restoration for the final result
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_quo_fixed;
    logic [WIDTH-1:0] w_rem_fixed;

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
        .i_neg (r_sign_q),
        .i_val (r_quo),
        .o_val (w_quo_fixed)
    );

    div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
        .i_neg (r_sign_r),
        .i_val (r_rem),
        .o_val (w_rem_fixed)
    );

    // ------------------------------------------------------------------
    // Controller and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_rem          <= '0;
            r_quo          <= '0;
            r_bmag         <= '0;
            r_cnt          <= '0;
            r_sign_q       <= 1'b0;
            r_sign_r       <= 1'b0;
            r_ovf          <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;

            if (ctrl_DIV) begin
                // A start always wins: whatever was in flight is dropped
                // without a ready pulse.
                r_sign_q <= w_a_neg ^ w_b_neg;
                r_sign_r <= w_a_neg;
                r_ovf    <= w_ovf;
                r_bmag   <= w_b_mag;
                r_rem    <= '0;
                r_cnt    <= CNT_LOAD;
                if (w_b_zero) begin
                    // Keep the raw dividend; it becomes the remainder.
                    r_quo   <= data_operandA;
                    r_state <= DZ;
                end else begin
                    r_quo   <= w_a_mag;
                    r_state <= RUN;
                end
            end else begin
                case (r_state)
                    RUN: begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        if (r_cnt == '0) begin
                            r_state <= FIX;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end

                    FIX: begin
                        // Overflow needs no special datapath: |MOST_NEG|/1
                        // yields MOST_NEG with remainder 0, which is already
                        // the wrapped answer; only the flag is raised.
                        data_result    <= w_quo_fixed;
                        data_remainder <= w_rem_fixed;
                        data_exception <= r_ovf;
                        data_resultRDY <= 1'b1;
                        r_state        <= IDLE;
                    end

                    DZ: begin
                        data_result    <= '0;
                        data_remainder <= r_quo;
                        data_exception <= 1'b1;
                        data_resultRDY <= 1'b1;
                        r_state        <= IDLE;
                    end

                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_iterative_divider.sv
// -----------------------------------------------------------------------------
// tb_iterative_divider
//   Three divider instances (4-bit unsigned, 32-bit signed, 32-bit unsigned)
//   share one clock and reset. Each start pushes the expected
//   {exception, remainder, quotient} and the expected ready cycle into that
//   instance's queue; every ready pulse pops and compares.
// -----------------------------------------------------------------------------
module tb_iterative_divider;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic        c_u4,  c_s32,  c_u32;
    logic [3:0]  a_u4,  b_u4,  q_u4,  r_u4;
    logic [31:0] a_s32, b_s32, q_s32, r_s32;
    logic [31:0] a_u32, b_u32, q_u32, r_u32;
    logic        x_u4,  x_s32, x_u32;
    logic        y_u4,  y_s32, y_u32;
    logic [1:0]  st_u4, st_s32, st_u32;

    iterative_divider #(.WIDTH(4), .SIGNED(0)) u_dut_u4 (
        .clock          (clk),
        .reset          (rst),
        .ctrl_DIV       (c_u4),
        .data_operandA  (a_u4),
        .data_operandB  (b_u4),
        .data_result    (q_u4),
        .data_remainder (r_u4),
        .data_exception (x_u4),
        .data_resultRDY (y_u4),
        .o_dbg_state    (st_u4)
    );

    iterative_divider #(.WIDTH(32), .SIGNED(1)) u_dut_s32 (
        .clock          (clk),
        .reset          (rst),
        .ctrl_DIV       (c_s32),
        .data_operandA  (a_s32),
        .data_operandB  (b_s32),
        .data_result    (q_s32),
        .data_remainder (r_s32),
        .data_exception (x_s32),
        .data_resultRDY (y_s32),
        .o_dbg_state    (st_s32)
    );

    iterative_divider #(.WIDTH(32), .SIGNED(0)) u_dut_u32 (
        .clock          (clk),
        .reset          (rst),
        .ctrl_DIV       (c_u32),
        .data_operandA  (a_u32),
        .data_operandB  (b_u32),
        .data_result    (q_u32),
        .data_remainder (r_u32),
        .data_exception (x_u32),
        .data_resultRDY (y_u32),
        .o_dbg_state    (st_u32)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [64:0] exp_q_u4[$];
    logic [64:0] exp_q_s32[$];
    logic [64:0] exp_q_u32[$];
    int          lat_q_u4[$];
    int          lat_q_s32[$];
    int          lat_q_u32[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: {exception, remainder, quotient}, fields zero-extended.
    function automatic logic [64:0] model(input int sel, input logic [31:0] a, input logic [31:0] b);
        logic [3:0]         a4;
        logic [3:0]         b4;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        a4 = a[3:0];
        b4 = b[3:0];
        sa = a;
        sb = b;
        if (sel == 0) begin
            if (b4 == 4'd0) return {1'b1, 28'd0, a4, 32'd0};
            return {1'b0, 28'd0, a4 % b4, 28'd0, a4 / b4};
        end else if (sel == 1) begin
            if (b == 32'd0) return {1'b1, a, 32'd0};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'd0, 32'h8000_0000};
            sq = sa / sb;
            sr = sa % sb;
            return {1'b0, sr, sq};
        end else begin
            if (b == 32'd0) return {1'b1, a, 32'd0};
            return {1'b0, a % b, a / b};
        end
    endfunction

    // ------------------------------------------------------------------
    // Driver: called between a falling and the next rising edge; that
    // rising edge is the start edge t0.
    // ------------------------------------------------------------------
    task automatic start_op(input int sel, input logic [31:0] a, input logic [31:0] b);
        logic [64:0] e;
        int          lat;
        e = model(sel, a, b);
        if (sel == 0) lat = cyc + 1 + ((b[3:0] == 4'd0) ? 1 : 5);
        else          lat = cyc + 1 + ((b == 32'd0) ? 1 : 33);
        case (sel)
            0: begin
                a_u4 = a[3:0]; b_u4 = b[3:0]; c_u4 = 1'b1;
                exp_q_u4.push_back(e); lat_q_u4.push_back(lat);
            end
            1: begin
                a_s32 = a; b_s32 = b; c_s32 = 1'b1;
                exp_q_s32.push_back(e); lat_q_s32.push_back(lat);
            end
            default: begin
                a_u32 = a; b_u32 = b; c_u32 = 1'b1;
                exp_q_u32.push_back(e); lat_q_u32.push_back(lat);
            end
        endcase
        @(negedge clk);
        c_u4  = 1'b0;
        c_s32 = 1'b0;
        c_u32 = 1'b0;
    endtask

    // Bounded wait until every queue has drained; leaves the caller just
    // after a falling edge.
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_q_u4.size() + exp_q_s32.size() + exp_q_u32.size()) != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_drained"}, 65'(exp_q_u4.size() + exp_q_s32.size() + exp_q_u32.size()), 65'd0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare each ready pulse against the queue head
    // ------------------------------------------------------------------
    task automatic on_rdy(input int sel, input logic [31:0] q, input logic [31:0] r,
                          input logic x, input logic y);
        logic [64:0] e;
        int          l;
        int          sz;
        string       nm;
        nm = (sel == 0) ? "u4" : (sel == 1) ? "s32" : "u32";
        sz = (sel == 0) ? exp_q_u4.size() : (sel == 1) ? exp_q_s32.size() : exp_q_u32.size();
        if (sz == 0) begin
            check({nm, "_unexpected_rdy"}, 65'(y), 65'd0);
        end else begin
            case (sel)
                0:       begin e = exp_q_u4.pop_front();  l = lat_q_u4.pop_front();  end
                1:       begin e = exp_q_s32.pop_front(); l = lat_q_s32.pop_front(); end
                default: begin e = exp_q_u32.pop_front(); l = lat_q_u32.pop_front(); end
            endcase
            check({nm, "_result"},    65'(q), 65'(e[31:0]));
            check({nm, "_remainder"}, 65'(r), 65'(e[63:32]));
            check({nm, "_exception"}, 65'(x), 65'(e[64]));
            check({nm, "_rdy_cycle"}, 65'(cyc), 65'(l));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (y_u4)  on_rdy(0, {28'd0, q_u4}, {28'd0, r_u4}, x_u4, y_u4);
            if (y_s32) on_rdy(1, q_s32, r_s32, x_s32, y_s32);
            if (y_u32) on_rdy(2, q_u32, r_u32, x_u32, y_u32);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          sel;
        int          kind;

        rst = 1'b1;
        c_u4 = 1'b0; c_s32 = 1'b0; c_u32 = 1'b0;
        a_u4 = '0; b_u4 = '0; a_s32 = '0; b_s32 = '0; a_u32 = '0; b_u32 = '0;

        repeat (3) @(negedge clk);
        check("rst_s32_result",    65'(q_s32), 65'd0);
        check("rst_s32_remainder", 65'(r_s32), 65'd0);
        check("rst_s32_exception", 65'(x_s32), 65'd0);
        check("rst_s32_rdy",       65'(y_s32), 65'd0);
        check("rst_s32_state",     65'(st_s32), 65'd0);
        check("rst_u4_rdy",        65'(y_u4), 65'd0);
        rst = 1'b0;

        // 13 / 3 on the 4-bit unsigned divider, then output hold
        start_op(0, 32'd13, 32'd3);
        wait_done("u4_13_3");
        @(negedge clk);
        check("u4_hold_result", 65'(q_u4), 65'd4);
        check("u4_hold_rdy",    65'(y_u4), 65'd0);

        // signed -7 / 2
        start_op(1, 32'hFFFF_FFF9, 32'd2);
        wait_done("s32_m7_2");

        // divide by zero on both 32-bit instances
        start_op(1, 32'h1234, 32'd0);
        wait_done("s32_dz");
        start_op(2, 32'h1234, 32'd0);
        wait_done("u32_dz");

        // signed overflow
        start_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("s32_ovf");

        // abort: start 100/7, restart at t10 with 50/5; only the second reports
        start_op(1, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        void'(exp_q_s32.pop_back());
        void'(lat_q_s32.pop_back());
        start_op(1, 32'd50, 32'd5);
        wait_done("s32_abort");

        // reset mid-operation around t15
        start_op(1, 32'd123456, 32'd7);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_result",    65'(q_s32), 65'd0);
        check("midrst_remainder", 65'(r_s32), 65'd0);
        check("midrst_state",     65'(st_s32), 65'd0);
        exp_q_s32.delete();
        lat_q_s32.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_no_rdy_result", 65'(q_s32), 65'd0);
        start_op(1, 32'd9, 32'd3);
        wait_done("s32_9_3");

        // random operands across all three instances
        for (int i = 0; i < 60; i++) begin
            sel  = i % 3;
            kind = $urandom_range(0, 7);
            a    = $urandom;
            b    = $urandom;
            case (kind)
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 9);
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_op(sel, a, b);
            wait_done("rnd");
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
